// File: rtl/clause_row8_pkg.sv
// Shared codes, default widths and literal evaluation helper
// for one clause row of the SAT implication array.
package clause_row8_pkg;

    localparam int DEF_NUM_VARS    = 8;
    localparam int DEF_WIDTH_LVL   = 16;
    localparam int DEF_WIDTH_C_LEN = 4;

    typedef enum logic [1:0] {
        VAL_FREE  = 2'b00,
        VAL_FALSE = 2'b01,
        VAL_TRUE  = 2'b10,
        VAL_ILL   = 2'b11
    } val_e;

    typedef enum logic [1:0] {
        LIT_ABS = 2'b00,
        LIT_NEG = 2'b01,
        LIT_POS = 2'b10,
        LIT_ILL = 2'b11
    } lit_e;

    typedef struct packed {
        logic is_true;
        logic is_false;
        logic is_free;
    } lit_eval_t;

    // Illegal codes (11) fall out as absent literal / free value.
    function automatic lit_eval_t eval_lit(
        input logic [1:0] lit,
        input logic [1:0] val
    );
        lit_eval_t r;
        logic      pos;
        logic      neg;
        logic      vt;
        logic      vf;
        pos        = (lit == LIT_POS);
        neg        = (lit == LIT_NEG);
        vt         = (val == VAL_TRUE);
        vf         = (val == VAL_FALSE);
        r.is_true  = (pos && vt) || (neg && vf);
        r.is_false = (pos && vf) || (neg && vt);
        r.is_free  = (pos || neg) && !vt && !vf;
        return r;
    endfunction

endpackage

// File: rtl/clause_row8_if.sv
// Load/read bus of a clause row: strobes, literal codes
// and clause length.
interface clause_row8_if
    import clause_row8_pkg::*;
#(
    parameter int NUM_VARS    = DEF_NUM_VARS,
    parameter int WIDTH_C_LEN = DEF_WIDTH_C_LEN
);

    logic                   wr_i;
    logic                   rd_i;
    logic [NUM_VARS*2-1:0]  clause_i;
    logic [NUM_VARS*2-1:0]  clause_o;
    logic [WIDTH_C_LEN-1:0] clause_len_i;
    logic [WIDTH_C_LEN-1:0] clause_len_o;

    modport master (
        output wr_i,
        output rd_i,
        output clause_i,
        output clause_len_i,
        input  clause_o,
        input  clause_len_o
    );

    modport slave (
        input  wr_i,
        input  rd_i,
        input  clause_i,
        input  clause_len_i,
        output clause_o,
        output clause_len_o
    );

endinterface

// File: rtl/clause_row8_terminal.sv
// Clause decision logic: satisfaction, free-literal count,
// unit implication, conflict detection and max false level.
module clause_terminal
    import clause_row8_pkg::*;
#(
    parameter int NUM_VARS  = DEF_NUM_VARS,
    parameter int WIDTH_LVL = DEF_WIDTH_LVL
) (
    input  logic [NUM_VARS-1:0]           lit_true_i,
    input  logic [NUM_VARS-1:0]           lit_false_i,
    input  logic [NUM_VARS-1:0]           lit_free_i,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_i,
    input  logic                          apply_imply_i,
    input  logic                          apply_analyze_i,
    output logic                          csat_o,
    output logic [1:0]                    freelitcnt_o,
    output logic                          imp_drv_o,
    output logic                          imp_fire_o,
    output logic                          all_lit_false_o,
    output logic                          conflict_c_drv_o,
    output logic [WIDTH_LVL-1:0]          cmax_lvl_o
);

    logic                 nonempty;
    logic [1:0]           cnt;
    logic [WIDTH_LVL-1:0] lvl_max;

    assign csat_o   = |lit_true_i;
    assign nonempty = |(lit_true_i | lit_false_i | lit_free_i);

    // Count stops at 2: only "none", "one" and "many" matter.
    always_comb begin
        cnt = 2'd0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (lit_free_i[i] && (cnt != 2'd2)) begin
                cnt = cnt + 2'd1;
            end
        end
    end

    always_comb begin
        lvl_max = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (lit_false_i[i] &&
                (var_lvl_i[i*WIDTH_LVL +: WIDTH_LVL] > lvl_max)) begin
                lvl_max = var_lvl_i[i*WIDTH_LVL +: WIDTH_LVL];
            end
        end
    end

    assign freelitcnt_o     = cnt;
    assign cmax_lvl_o       = lvl_max;
    assign imp_drv_o        = !csat_o && (cnt == 2'd1);
    assign imp_fire_o       = apply_imply_i && imp_drv_o;
    assign all_lit_false_o  = nonempty && !csat_o && (cnt == 2'd0);
    assign conflict_c_drv_o = all_lit_false_o && apply_analyze_i;

endmodule

// File: rtl/clause_row8.sv
// One clause row: literal store, per-slot evaluation, implication
// drive onto the down chain, conflict participation and reason state.
module clause_row8
    import clause_row8_pkg::*;
#(
    parameter int NUM_VARS    = DEF_NUM_VARS,
    parameter int WIDTH_LVL   = DEF_WIDTH_LVL,
    parameter int WIDTH_C_LEN = DEF_WIDTH_C_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_VARS*3-1:0]         var_value_i,
    input  logic [NUM_VARS*3-1:0]         var_value_down_i,
    output logic [NUM_VARS*3-1:0]         var_value_down_o,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_i,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_down_i,
    output logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_down_o,
    output logic [NUM_VARS-1:0]           participate_o,
    input  logic                          apply_imply_i,
    input  logic                          apply_analyze_i,
    input  logic                          apply_bkt_i,
    output logic                          all_c_sat_o,
    clause_row8_if.slave                  bus
);

    logic [NUM_VARS*2-1:0]  lits_q,     lits_d;
    logic [WIDTH_C_LEN-1:0] len_q,      len_d;
    logic                   reason_q,   reason_d;
    logic                   nclr_q,     nclr_d;

    logic [NUM_VARS-1:0]    lit_true;
    logic [NUM_VARS-1:0]    lit_false;
    logic [NUM_VARS-1:0]    lit_free;
    logic [NUM_VARS-1:0]    lit_pos;
    logic [NUM_VARS-1:0]    present;
    logic [NUM_VARS-1:0]    unused_imp;

    logic                   csat;
    logic [1:0]             freelitcnt;
    logic                   imp_drv;
    logic                   imp_fire;
    logic                   all_lit_false;
    logic                   conflict_c_drv;
    logic [WIDTH_LVL-1:0]   cmax_lvl;

    always_comb begin
        lit_true   = '0;
        lit_false  = '0;
        lit_free   = '0;
        lit_pos    = '0;
        present    = '0;
        unused_imp = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            lit_eval_t e;
            e = eval_lit(lits_q[2*i +: 2], var_value_i[3*i +: 2]);
            lit_true[i]   = e.is_true;
            lit_false[i]  = e.is_false;
            lit_free[i]   = e.is_free;
            lit_pos[i]    = (lits_q[2*i +: 2] == LIT_POS);
            present[i]    = (lits_q[2*i +: 2] == LIT_POS) ||
                            (lits_q[2*i +: 2] == LIT_NEG);
            unused_imp[i] = var_value_i[3*i+2];
        end
    end

    clause_terminal #(
        .NUM_VARS  (NUM_VARS),
        .WIDTH_LVL (WIDTH_LVL)
    ) u_term (
        .lit_true_i       (lit_true),
        .lit_false_i      (lit_false),
        .lit_free_i       (lit_free),
        .var_lvl_i        (var_lvl_i),
        .apply_imply_i    (apply_imply_i),
        .apply_analyze_i  (apply_analyze_i),
        .csat_o           (csat),
        .freelitcnt_o     (freelitcnt),
        .imp_drv_o        (imp_drv),
        .imp_fire_o       (imp_fire),
        .all_lit_false_o  (all_lit_false),
        .conflict_c_drv_o (conflict_c_drv),
        .cmax_lvl_o       (cmax_lvl)
    );

    // The single free slot is overridden; all others pass through.
    always_comb begin
        var_value_down_o = var_value_down_i;
        var_lvl_down_o   = var_lvl_down_i;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (imp_fire && lit_free[i]) begin
                var_value_down_o[3*i +: 3] =
                    {1'b1, lit_pos[i] ? VAL_TRUE : VAL_FALSE};
                var_lvl_down_o[i*WIDTH_LVL +: WIDTH_LVL] = cmax_lvl;
            end
        end
    end

    assign participate_o    = {NUM_VARS{conflict_c_drv}} & present;
    assign all_c_sat_o      = csat || (lits_q == '0);
    assign bus.clause_o     = bus.rd_i ? lits_q : '0;
    assign bus.clause_len_o = reason_q ? '0 : len_q;

    always_comb begin
        lits_d = lits_q;
        len_d  = len_q;
        if (bus.wr_i) begin
            lits_d = bus.clause_i;
            len_d  = bus.clause_len_i;
        end
    end

    always_comb begin
        reason_d = reason_q;
        if (imp_fire) begin
            reason_d = 1'b1;
        end else if (apply_bkt_i && nclr_q) begin
            reason_d = 1'b0;
        end
    end

    always_comb begin
        nclr_d = nclr_q;
        if (reason_q && conflict_c_drv) begin
            nclr_d = 1'b1;
        end else if (!reason_q) begin
            nclr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lits_q   <= '0;
            len_q    <= '0;
            reason_q <= 1'b0;
            nclr_q   <= 1'b0;
        end else begin
            lits_q   <= lits_d;
            len_q    <= len_d;
            reason_q <= reason_d;
            nclr_q   <= nclr_d;
        end
    end

    logic unused_sig;
    assign unused_sig = ^{unused_imp, freelitcnt, all_lit_false, imp_drv};

endmodule

// File: tb/tb_clause_row8.sv
// Directed-vector bench for clause_row8: implication, conflict,
// backtrack, load/evaluate overlap and asynchronous reset.
module tb_clause_row8;

    logic         clk = 1'b0;
    logic         rst;
    logic [23:0]  vv, vdi, vdo;
    logic [127:0] lv, ldi, ldo;
    logic [7:0]   part;
    logic         ap_imp, ap_ana, ap_bkt;
    logic         all_sat;
    logic [23:0]  exp_v;
    logic [127:0] exp_l;
    int           n_cmp = 0;
    int           n_bad = 0;

    clause_row8_if bus ();

    clause_row8 dut (
        .clk              (clk),
        .rst              (rst),
        .var_value_i      (vv),
        .var_value_down_i (vdi),
        .var_value_down_o (vdo),
        .var_lvl_i        (lv),
        .var_lvl_down_i   (ldi),
        .var_lvl_down_o   (ldo),
        .participate_o    (part),
        .apply_imply_i    (ap_imp),
        .apply_analyze_i  (ap_ana),
        .apply_bkt_i      (ap_bkt),
        .all_c_sat_o      (all_sat),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [2:0] v,
                            input logic [15:0] l);
        vv[3*i +: 3]  = v;
        lv[16*i +: 16] = l;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b0;
        vv               = '0;
        lv               = '0;
        vdi              = 24'h5ac396;
        ldi              = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        ap_imp           = 1'b0;
        ap_ana           = 1'b0;
        ap_bkt           = 1'b0;
        bus.wr_i         = 1'b1;
        bus.rd_i         = 1'b0;
        bus.clause_i     = 16'hffff;
        bus.clause_len_i = 4'hf;

        // Reset held: writes ignored, outputs at their reset values
        edge_step();
        edge_step();
        chk("rst_clause_o", bus.clause_o, 16'h0);
        chk("rst_len", bus.clause_len_o, 4'h0);
        chk("rst_sat", all_sat, 1'b1);
        chk("rst_part", part, 8'h00);
        chk("rst_vdn", vdo, vdi);
        chk("rst_ldn", ldo, ldi);
        bus.rd_i = 1'b1;
        #1;
        chk("rst_rd_clause", bus.clause_o, 16'h0);

        // Load slot0 pos, slot1 neg, length 2
        rst              = 1'b1;
        bus.clause_i     = 16'h0006;
        bus.clause_len_i = 4'd2;
        edge_step();
        bus.wr_i = 1'b0;
        #1;
        chk("load_rd", bus.clause_o, 16'h0006);
        chk("load_len", bus.clause_len_o, 4'd2);
        bus.rd_i = 1'b0;
        #1;
        chk("rd_off", bus.clause_o, 16'h0);

        // Unit implication on slot1
        set_slot(0, 3'b001, 16'd3);
        set_slot(1, 3'b000, 16'd9);
        ap_imp = 1'b1;
        #1;
        exp_v = vdi;
        exp_v[5:3] = 3'b101;
        exp_l = ldi;
        exp_l[31:16] = 16'd3;
        chk("imp_vdn", vdo, exp_v);
        chk("imp_ldn", ldo, exp_l);
        chk("imp_sat", all_sat, 1'b0);
        edge_step();
        ap_imp = 1'b0;
        #1;
        chk("imp_len", bus.clause_len_o, 4'd0);
        chk("imp_off_pass", vdo, vdi);

        // Backtrack without a prior conflict keeps the reason
        ap_bkt = 1'b1;
        edge_step();
        ap_bkt = 1'b0;
        #1;
        chk("bkt_noclr", bus.clause_len_o, 4'd0);

        // Conflict: both literals false
        set_slot(0, 3'b001, 16'd2);
        set_slot(1, 3'b010, 16'd5);
        ap_ana = 1'b1;
        #1;
        chk("cfl_part", part, 8'h03);
        chk("cfl_sat", all_sat, 1'b0);
        chk("cfl_pass", vdo, vdi);
        edge_step();
        ap_ana = 1'b0;
        ap_bkt = 1'b1;
        #1;
        chk("cfl_off_part", part, 8'h00);
        edge_step();
        ap_bkt = 1'b0;
        #1;
        chk("bkt_restore", bus.clause_len_o, 4'd2);

        // Satisfied clause: no implication
        set_slot(0, 3'b010, 16'd2);
        set_slot(1, 3'b000, 16'd5);
        ap_imp = 1'b1;
        #1;
        chk("sat_sat", all_sat, 1'b1);
        chk("sat_vdn", vdo, vdi);
        chk("sat_ldn", ldo, ldi);
        edge_step();
        ap_imp = 1'b0;
        #1;
        chk("sat_len", bus.clause_len_o, 4'd2);

        // Two free literals (11 counts as free)
        set_slot(0, 3'b011, 16'd2);
        set_slot(1, 3'b000, 16'd5);
        ap_imp = 1'b1;
        ap_ana = 1'b1;
        #1;
        chk("two_vdn", vdo, vdi);
        chk("two_ldn", ldo, ldi);
        chk("two_part", part, 8'h00);
        chk("two_sat", all_sat, 1'b0);
        edge_step();
        ap_imp = 1'b0;
        ap_ana = 1'b0;
        #1;
        chk("two_len", bus.clause_len_o, 4'd2);

        // Unit clause on slot3: no false literals, level 0
        bus.wr_i         = 1'b1;
        bus.clause_i     = 16'h0080;
        bus.clause_len_i = 4'd1;
        edge_step();
        bus.wr_i = 1'b0;
        set_slot(3, 3'b000, 16'd11);
        ap_imp = 1'b1;
        #1;
        exp_v = vdi;
        exp_v[11:9] = 3'b110;
        exp_l = ldi;
        exp_l[63:48] = 16'd0;
        chk("unit_vdn", vdo, exp_v);
        chk("unit_ldn", ldo, exp_l);
        edge_step();
        ap_imp = 1'b0;
        #1;
        chk("unit_len", bus.clause_len_o, 4'd0);

        // Write during analyze: old literals now, new ones next cycle
        set_slot(3, 3'b001, 16'd4);
        set_slot(0, 3'b001, 16'd6);
        set_slot(1, 3'b000, 16'd1);
        bus.wr_i         = 1'b1;
        bus.clause_i     = 16'h0009;
        bus.clause_len_i = 4'd3;
        ap_ana           = 1'b1;
        #1;
        chk("ovl_old_part", part, 8'h08);
        chk("ovl_old_sat", all_sat, 1'b0);
        edge_step();
        bus.wr_i = 1'b0;
        #1;
        chk("ovl_new_part", part, 8'h00);
        chk("ovl_new_sat", all_sat, 1'b1);
        ap_ana   = 1'b0;
        bus.rd_i = 1'b1;
        #1;
        chk("ovl_rd", bus.clause_o, 16'h0009);
        bus.rd_i = 1'b0;
        ap_bkt   = 1'b1;
        edge_step();
        ap_bkt = 1'b0;
        #1;
        chk("ovl_bkt_len", bus.clause_len_o, 4'd3);

        // Reset asserted mid-implication
        set_slot(0, 3'b010, 16'd7);
        set_slot(1, 3'b000, 16'd2);
        ap_imp = 1'b1;
        #1;
        exp_v = vdi;
        exp_v[5:3] = 3'b110;
        exp_l = ldi;
        exp_l[31:16] = 16'd7;
        chk("pre_rst_vdn", vdo, exp_v);
        chk("pre_rst_ldn", ldo, exp_l);
        edge_step();
        rst      = 1'b0;
        bus.rd_i = 1'b1;
        #1;
        chk("arst_clause", bus.clause_o, 16'h0);
        chk("arst_len", bus.clause_len_o, 4'd0);
        chk("arst_sat", all_sat, 1'b1);
        chk("arst_vdn", vdo, vdi);
        chk("arst_ldn", ldo, ldi);
        chk("arst_part", part, 8'h00);
        ap_imp           = 1'b0;
        rst              = 1'b1;
        bus.rd_i         = 1'b0;
        bus.wr_i         = 1'b1;
        bus.clause_i     = 16'h0006;
        bus.clause_len_i = 4'd5;
        edge_step();
        bus.wr_i = 1'b0;
        #1;
        chk("post_rst_len", bus.clause_len_o, 4'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clause_row8.md
CLAUSE_ROW8 -- requirements
Module: clause_row8

Interface
REQ-001 The block SHALL have parameter NUM_VARS, default 8, giving the number of variable slots.
REQ-002 The block SHALL have parameter WIDTH_LVL, default 16, giving the decision-level width.
REQ-003 The block SHALL have parameter WIDTH_C_LEN, default 4, giving the clause-length width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset: asynchronous assert, active-low.
REQ-007 var_value_i  in  NUM_VARS*3  current variable values, slot i at bits [3i+2:3i].
REQ-008 var_value_down_i / var_value_down_o  in/out  NUM_VARS*3  implication chain from the row above, passed to the row below.
REQ-009 var_lvl_i  in  NUM_VARS*WIDTH_LVL  current variable levels.
REQ-010 var_lvl_down_i / var_lvl_down_o  in/out  NUM_VARS*WIDTH_LVL  level chain.
REQ-011 participate_o  out  NUM_VARS  flags the variables that take part in a conflict.
REQ-012 wr_i, rd_i  in  1  load and read strobes.
REQ-013 clause_i / clause_o  in/out  NUM_VARS*2  literal codes.
REQ-014 clause_len_i / clause_len_o  in/out  WIDTH_C_LEN  clause length.
REQ-015 apply_imply_i, apply_analyze_i, apply_bkt_i  in  1  phase controls.
REQ-016 all_c_sat_o  out  1  clause satisfied or empty.

Function
REQ-017 Value code: bits [1:0] are 00 free, 01 false, 10 true, and 11 is illegal, treated as free; bit [2] is the implied flag.
REQ-018 Literal code: 00 absent, 01 negative, 10 positive, and 11 is treated as absent.
REQ-019 wr_i=1 SHALL register clause_i into the literal store and clause_len_i into clause_len_r at the clk edge.
REQ-020 clause_o SHALL be combinational: the stored literals when rd_i=1, otherwise 0.
REQ-021 Per present literal, combinationally: true if (pos and value=10) or (neg and value=01); false if the opposite; free if value=00.
REQ-022 csat SHALL be the OR of the literal-true flags.
REQ-023 freelitcnt SHALL saturate at 2: 0, 1, or 2 meaning two or more.
REQ-024 all_lit_false SHALL be 1 when the clause is nonempty, csat=0 and freelitcnt=0.
REQ-025 cmax_lvl SHALL be the maximum var_lvl_i over the false literals, and 0 if there are none.
REQ-026 imp_drv SHALL equal ~csat & (freelitcnt==1).
REQ-027 When apply_imply_i & imp_drv, the single free slot SHALL output {1'b1, the value making its literal true} on var_value_down_o and cmax_lvl on var_lvl_down_o.
REQ-028 All other slots, and all slots when imp_drv=0 or apply_imply_i=0, SHALL pass var_value_down_i and var_lvl_down_i through unchanged.
REQ-029 conflict_c_drv SHALL equal all_lit_false & apply_analyze_i.
REQ-030 participate_o[i] SHALL equal conflict_c_drv & (literal i present); otherwise 0.
REQ-031 all_c_sat_o SHALL equal csat | (the literal store is all zero).
REQ-032 is_reason_r SHALL be set by apply_imply_i & imp_drv.
REQ-033 is_reason_r SHALL be cleared by apply_bkt_i & need_clear; set has priority when both occur.
REQ-034 need_clear SHALL be set by is_reason_r & conflict_c_drv, SHALL be cleared when is_reason_r=0, and SHALL hold otherwise.
REQ-035 clause_len_o SHALL be 0 while is_reason_r=1, otherwise clause_len_r.
REQ-036 The imply, conflict and pass-through paths SHALL be combinational with zero-cycle latency; state changes take effect the cycle after the enabling edge.
REQ-037 wr_i together with an apply_* strobe SHALL evaluate the old literals this cycle and the new literals from the next cycle.

Reset
REQ-038 rst=0 SHALL asynchronously clear the literal store, clause_len_r, is_reason_r and need_clear.
REQ-039 During reset: clause_o=0 (rd_i=0), clause_len_o=0, all_c_sat_o=1, participate_o=0, and the down buses equal their _i inputs.
REQ-040 Reset asserted mid-operation SHALL drop any pending implication or reason state immediately.

Structure
REQ-041 The value codes, literal codes and default widths SHALL be placed in a shared package, e.g. sat_pkg.
REQ-042 One sub-module, clause_terminal, SHALL hold the freelitcnt, imp_drv, conflict and cmax decision logic.
REQ-043 The literal store and per-slot lit evaluation SHALL stay in clause_row8.

Verification
REQ-044 Load clause_i=16'h0006 (slot0 pos, slot1 neg), values slot0=01 lvl 3, slot1=00, apply_imply_i=1 -> slot1 down_o=3'b101, lvl_down_o=3, clause_len_o=0 next cycle.
REQ-045 Same clause, slot0=01 lvl 2, slot1=10 lvl 5, apply_analyze_i=1 -> participate_o=8'h03, and need_clear=1 next cycle if is_reason_r=1.
REQ-046 Slot0=10 -> all_c_sat_o=1, no implication, and down buses equal their inputs.
REQ-047 Two free literals -> freelitcnt=2, imp_drv=0, and no drive on the down buses.
REQ-048 Implication, then conflict, then apply_bkt_i -> is_reason_r=0 and clause_len_o restored to the loaded length, e.g. 2.
REQ-049 Assert rst mid-implication -> every register clears asynchronously; rd_i=1 returns clause_o=0.
